// File: rtl/router_pkt_tx.sv
// Router input-port packet source.
// Takes one (addr, len) command and buffers the whole payload. It then sends the frame
// without bubbles: a header, len payload bytes and a trailing parity byte. Every byte is
// held on tx_data until the router consumes it at a clock edge where busy is low.
`timescale 1ns/1ps
module router_pkt_tx #(
  parameter int unsigned IPG_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             cmd_inj_err,
  input  logic             pay_valid,
  output logic             pay_ready,
  input  logic [7:0]       pay_data,
  input  logic             busy,
  output logic [7:0]       tx_data,
  output logic             pkt_valid,
  output logic             tx_active,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int unsigned GapW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StHeader, StPayload, StParity, StGap} state_e;

  state_e           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [5:0]       len_q, len_d;
  logic             inj_q, inj_d;
  logic [7:0]       acc_q, acc_d;
  logic [5:0]       wr_idx_q, wr_idx_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mem_q [64];

  logic cmd_fire, pay_fire;

  // Handshakes decode straight from state; cmd_ready is forced low while reset is held.
  assign cmd_ready  = (state_q == StIdle) & ~reset;
  assign pay_ready  = (state_q == StLoad);
  assign tx_active  = (state_q != StIdle);
  assign drop_pulse = drop_q;
  assign pkt_count  = cnt_q;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign pay_fire   = pay_valid & pay_ready;

  // Next-state logic: command intake, payload load, frame transmit and inter-packet gap.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    inj_d    = inj_q;
    acc_d    = acc_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    gap_d    = gap_q;
    drop_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
            drop_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            len_d    = cmd_len;
            inj_d    = cmd_inj_err;
            acc_d    = {cmd_len, cmd_addr};
            wr_idx_d = 6'd0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (pay_fire) begin
          acc_d    = acc_q ^ pay_data;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == len_q - 6'd1) state_d = StHeader;
        end
      end
      StHeader: begin
        if (!busy) begin
          rd_idx_d = 6'd0;
          state_d  = StPayload;
        end
      end
      StPayload: begin
        if (!busy) begin
          rd_idx_d = rd_idx_q + 6'd1;
          if (rd_idx_q == len_q - 6'd1) state_d = StParity;
        end
      end
      StParity: begin
        if (!busy) begin
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = '0;
          state_d = (IPG_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // State and control registers; reset aborts any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      inj_q    <= 1'b0;
      acc_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      gap_q    <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      inj_q    <= inj_d;
      acc_q    <= acc_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      gap_q    <= gap_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload buffer write; the contents are don't-care until loaded, so there is no reset.
  always_ff @(posedge clock) begin
    if (pay_fire) mem_q[wr_idx_q] <= pay_data;
  end

  // Bus outputs decode from registered state and read index only, never from busy.
  always_comb begin
    tx_data   = 8'h00;
    pkt_valid = 1'b0;
    unique case (state_q)
      StHeader: begin
        tx_data   = {len_q, addr_q};
        pkt_valid = 1'b1;
      end
      StPayload: begin
        tx_data   = mem_q[rd_idx_q];
        pkt_valid = 1'b1;
      end
      StParity: tx_data = acc_q ^ {8{inj_q}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus random frames, each
// checked against an expected byte stream built from the frame format rules.
`timescale 1ns/1ps
module tb_router_pkt_tx;

  localparam int unsigned IPG = 2;
  localparam int unsigned CW  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_addr = '0;
  logic [5:0]    cmd_len = '0;
  logic          cmd_inj_err = 1'b0;
  logic          pay_valid = 1'b0;
  logic          pay_ready;
  logic [7:0]    pay_data = '0;
  logic          busy = 1'b0;
  logic [7:0]    tx_data;
  logic          pkt_valid;
  logic          tx_active;
  logic          drop_pulse;
  logic [CW-1:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  router_pkt_tx #(.IPG_CYCLES(IPG), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_inj_err(cmd_inj_err),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data), .busy(busy),
    .tx_data(tx_data), .pkt_valid(pkt_valid), .tx_active(tx_active),
    .drop_pulse(drop_pulse), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int l);
    pay_q.delete();
    for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
  endtask

  // Expected frame: header {len,addr}, payload, then XOR of all of those (inverted on inject).
  task automatic build_exp(input logic [1:0] a, input logic [5:0] l, input logic inj);
    logic [7:0] par;
    exp_q.delete();
    exp_q.push_back({l, a});
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    par = 8'h00;
    foreach (exp_q[i]) par = par ^ exp_q[i];
    if (inj) par = ~par;
    exp_q.push_back(par);
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic inj);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_inj_err = inj;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    chk("cmd_pay_excl", {31'd0, pay_ready}, 32'd0);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic load_payload(input int unsigned gap_pct);
    for (int i = 0; i < pay_q.size(); i++) begin
      int ng = 0;
      int n = 0;
      while (ng < 3 && $urandom_range(99) < gap_pct) begin
        pay_valid = 1'b0;
        busy = 1'($urandom_range(1));
        chk("load_idle_bus", {23'd0, pkt_valid, tx_data}, 32'd0);
        @(negedge clock);
        ng++;
      end
      pay_valid = 1'b1;
      pay_data  = pay_q[i];
      busy = 1'($urandom_range(1));
      while (pay_ready !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("pay_ready", {31'd0, pay_ready}, 32'd1);
      chk("pay_cmd_excl", {31'd0, cmd_ready}, 32'd0);
      chk("load_bus", {23'd0, pkt_valid, tx_data}, 32'd0);
      @(negedge clock);
    end
    pay_valid = 1'b0;
    busy = 1'b0;
  endtask

  // Consume the frame under a busy pattern; every cycle the unconsumed byte must be shown.
  task automatic tx_frame(input int unsigned busy_pct, input int stall_at, input int stall_n);
    int k = 0;
    int held = 0;
    int cyc = 0;
    int len_i;
    len_i = exp_q.size() - 2;
    while (k < exp_q.size() && cyc < 1000) begin
      if (k == stall_at && held < stall_n) begin
        busy = 1'b1;
        held++;
      end else begin
        busy = ($urandom_range(99) < busy_pct);
      end
      chk("tx_byte", {23'd0, pkt_valid, tx_data}, {23'd0, (k <= len_i), exp_q[k]});
      if (!busy) k++;
      cyc++;
      @(negedge clock);
    end
    chk("tx_done", k, exp_q.size());
    exp_count = (exp_count + 1) % (1 << CW);
    chk("pkt_count", {29'd0, pkt_count}, exp_count);
    chk("gap_active", {31'd0, tx_active}, 32'd1);
    chk("gap_bus", {23'd0, pkt_valid, tx_data}, 32'd0);
    for (int g = 0; g < IPG; g++) begin
      chk("gap_no_cmd", {31'd0, cmd_ready}, 32'd0);
      busy = 1'($urandom_range(1));
      @(negedge clock);
    end
    busy = 1'b0;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_active", {31'd0, tx_active}, 32'd0);
  endtask

  task automatic frame(input logic [1:0] a, input logic [5:0] l, input logic inj,
                       input int unsigned gap_pct, input int unsigned busy_pct,
                       input int stall_at, input int stall_n);
    build_exp(a, l, inj);
    send_cmd(a, l, inj);
    load_payload(gap_pct);
    tx_frame(busy_pct, stall_at, stall_n);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
    chk("rst_bus", {23'd0, pkt_valid, tx_data}, 32'd0);
    chk("rst_active", {31'd0, tx_active}, 32'd0);
    chk("rst_drop", {31'd0, drop_pulse}, 32'd0);
    chk("rst_count", {29'd0, pkt_count}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Basic frame: addr 1, len 3, 11/22/33
    pay_q = '{8'h11, 8'h22, 8'h33};
    frame(2'd1, 6'd3, 1'b0, 0, 0, -1, 0);

    // Same frame with busy held for 2 cycles on byte 0x22
    pay_q = '{8'h11, 8'h22, 8'h33};
    frame(2'd1, 6'd3, 1'b0, 0, 0, 2, 2);

    // Illegal commands: addr 3, then len 0
    send_cmd(2'd3, 6'd5, 1'b0);
    chk("drop_a3", {31'd0, drop_pulse}, 32'd1);
    chk("drop_a3_pay", {31'd0, pay_ready}, 32'd0);
    chk("drop_a3_bus", {24'd0, pkt_valid, tx_active, tx_data[5:0]}, 32'd0);
    @(negedge clock);
    chk("drop_a3_end", {31'd0, drop_pulse}, 32'd0);
    chk("drop_a3_idle", {31'd0, cmd_ready}, 32'd1);
    send_cmd(2'd2, 6'd0, 1'b0);
    chk("drop_l0", {31'd0, drop_pulse}, 32'd1);
    chk("drop_l0_pay", {31'd0, pay_ready}, 32'd0);
    chk("drop_l0_act", {31'd0, tx_active}, 32'd0);
    @(negedge clock);
    chk("drop_l0_end", {31'd0, drop_pulse}, 32'd0);
    chk("drop_count", {29'd0, pkt_count}, exp_count);

    // Error injection: addr 0, len 1, 0xA5
    pay_q = '{8'hA5};
    frame(2'd0, 6'd1, 1'b1, 0, 0, -1, 0);

    // Full buffer with payload gaps and random busy
    fill_random(63);
    frame(2'($urandom_range(2)), 6'd63, 1'b0, 40, 30, -1, 0);

    // Reset while in PAYLOAD aborts the frame
    fill_random(10);
    build_exp(2'd2, 6'd10, 1'b0);
    send_cmd(2'd2, 6'd10, 1'b0);
    load_payload(0);
    repeat (3) @(negedge clock);
    chk("mid_payload", {23'd0, pkt_valid, tx_data}, {23'd0, 1'b1, pay_q[2]});
    reset = 1'b1;
    #1;
    chk("abort_bus", {23'd0, pkt_valid, tx_data}, 32'd0);
    chk("abort_active", {31'd0, tx_active}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_count", {29'd0, pkt_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    @(negedge clock);

    // Random frames; more than 2^CW of them so pkt_count wraps
    for (int f = 0; f < 10; f++) begin
      fill_random(int'($urandom_range(63, 1)));
      frame(2'($urandom_range(2)), 6'(pay_q.size()), 1'($urandom_range(1)), 30, 40, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
